// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern sequencer: FSM state encoding,
// table entry layout (40-bit {PAT, pulse_num, pulse_dessert, duty_num}).
package pattern_seq_pkg;

  localparam int unsigned ENTRY_W  = 40;

  localparam int unsigned DUTY_W   = 8;
  localparam int unsigned DUTY_LSB = 0;
  localparam int unsigned DES_W    = 16;
  localparam int unsigned DES_LSB  = 8;
  localparam int unsigned PNUM_W   = 8;
  localparam int unsigned PNUM_LSB = 24;
  localparam int unsigned PAT_W    = 8;
  localparam int unsigned PAT_LSB  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StWait,
    StDone
  } state_e;

  typedef struct packed {
    logic [PAT_W-1:0]  pat;
    logic [PNUM_W-1:0] pulse_num;
    logic [DES_W-1:0]  pulse_dessert;
    logic [DUTY_W-1:0] duty_num;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    entry_t e;
    e.duty_num      = raw[DUTY_LSB +: DUTY_W];
    e.pulse_dessert = raw[DES_LSB +: DES_W];
    e.pulse_num     = raw[PNUM_LSB +: PNUM_W];
    e.pat           = raw[PAT_LSB +: PAT_W];
    return e;
  endfunction

endpackage

// File: rtl/pattern_seq_table.sv
// Pattern table: DEPTH x 40-bit register file, synchronous write,
// asynchronous read, cleared by synchronous reset.
module pattern_seq_table
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [ENTRY_W-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [ENTRY_W-1:0]       o_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_wr_ok;
  logic               w_rd_ok;

  // Addresses past DEPTH only exist when DEPTH is not a power of two
  if (DEPTH == (1 << AW)) begin : g_full
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
  end else begin : g_part
    assign w_wr_ok = (32'(i_waddr) < DEPTH);
    assign w_rd_ok = (32'(i_raddr) < DEPTH);
  end

  // Storage: reset clears every entry, otherwise accept guarded writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Pattern sequence controller: plays table entries to a downstream pulse
// generator, one burst per entry, for a number of passes.
// Optional watchdog on WAIT enabled by defining PATTERN_SEQ_TIMEOUT_EN.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned _PAT_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [ENTRY_W-1:0]       cfg_wdata,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic [7:0]               loop_num,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     gen_busy,
  input  logic                     gen_valid,
  output logic                     pwm_en,
  output logic [7:0]               duty_num,
  output logic [15:0]              pulse_dessert,
  output logic [7:0]               pulse_num,
  output logic [_PAT_WIDTH-1:0]    PAT,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                     seq_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("DEPTH must be in 2..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [7:0]        r_pass_cnt, w_pass_nxt;
  logic              r_stop_lat, w_stop_nxt;
  logic              r_pwm_en, w_pwm_nxt;
  logic              w_load;
  logic [AW-1:0]     r_cur_idx;
  logic [7:0]        r_duty;
  logic [15:0]       r_des;
  logic [7:0]        r_pnum;
  logic [_PAT_WIDTH-1:0] r_pat;

  logic [ENTRY_W-1:0] w_rd_raw;
  entry_t             w_rd;
  logic [LW-1:0]      w_len;
  logic               w_last;
  logic               w_stop_seen;
  logic [7:0]         w_pass_inc;

  pattern_seq_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (cfg_we && (r_state == StIdle)),
    .i_waddr(cfg_addr),
    .i_wdata(cfg_wdata),
    .i_raddr(r_idx),
    .o_rdata(w_rd_raw)
  );

  assign w_rd        = unpack_entry(w_rd_raw);
  assign w_len       = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
  assign w_last      = (LW'(r_idx) + LW'(1)) >= w_len;
  assign w_stop_seen = r_stop_lat | stop;
  // Saturate so an infinite loop never wraps the pass counter
  assign w_pass_inc  = (r_pass_cnt == 8'hFF) ? 8'hFF : r_pass_cnt + 8'd1;

`ifdef PATTERN_SEQ_TIMEOUT_EN
  logic [31:0] r_to_cnt, w_to_nxt;
  logic        r_err, w_err_nxt;
`endif

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pass_nxt  = r_pass_cnt;
    w_stop_nxt  = r_stop_lat;
    w_pwm_nxt   = 1'b0;
    w_load      = 1'b0;
`ifdef PATTERN_SEQ_TIMEOUT_EN
    w_to_nxt    = r_to_cnt;
    w_err_nxt   = r_err;
`endif
    unique case (r_state)
      StIdle: begin
        if (start && !stop && !gen_busy && (seq_len != '0)) begin
          w_state_nxt = StLoad;
          w_idx_nxt   = '0;
          w_pass_nxt  = '0;
          w_stop_nxt  = 1'b0;
`ifdef PATTERN_SEQ_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (stop) begin
          w_state_nxt = StDone;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = StArm;
        end
      end
      StArm: begin
        if (stop) begin
          w_state_nxt = StDone;
        end else begin
          w_pwm_nxt   = 1'b1;
          w_state_nxt = StWait;
`ifdef PATTERN_SEQ_TIMEOUT_EN
          w_to_nxt    = '0;
`endif
        end
      end
      StWait: begin
        w_stop_nxt = w_stop_seen;
        // Infinite entries keep the generator enabled until a stop arrives
        w_pwm_nxt  = (r_pnum == '0) && !w_stop_seen;
        if (gen_valid) begin
          w_pwm_nxt = 1'b0;
          if (w_stop_seen) begin
            w_state_nxt = StDone;
          end else if (!w_last) begin
            w_idx_nxt   = r_idx + AW'(1);
            w_state_nxt = StLoad;
          end else begin
            w_pass_nxt = w_pass_inc;
            if ((loop_num != '0) && (w_pass_inc == loop_num)) begin
              w_state_nxt = StDone;
            end else begin
              w_idx_nxt   = '0;
              w_state_nxt = StLoad;
            end
          end
        end
`ifdef PATTERN_SEQ_TIMEOUT_EN
        else if ((r_pnum != '0) && (r_to_cnt >= TIMEOUT_CYC - 1)) begin
          w_err_nxt   = 1'b1;
          w_pwm_nxt   = 1'b0;
          w_state_nxt = StDone;
        end else begin
          w_to_nxt = r_to_cnt + 32'd1;
        end
`endif
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State, sequencing counters and the entry fields presented downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_pass_cnt <= '0;
      r_stop_lat <= 1'b0;
      r_pwm_en   <= 1'b0;
      r_cur_idx  <= '0;
      r_duty     <= '0;
      r_des      <= '0;
      r_pnum     <= '0;
      r_pat      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_stop_lat <= w_stop_nxt;
      r_pwm_en   <= w_pwm_nxt;
      if (w_load) begin
        r_cur_idx <= r_idx;
        r_duty    <= w_rd.duty_num;
        r_des     <= w_rd.pulse_dessert;
        r_pnum    <= w_rd.pulse_num;
        r_pat     <= _PAT_WIDTH'(w_rd.pat);
      end
    end
  end

`ifdef PATTERN_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_nxt;
      r_err    <= w_err_nxt;
    end
  end
  assign seq_err = r_err;
`else
  assign seq_err = 1'b0;
`endif

  assign pwm_en        = r_pwm_en;
  assign duty_num      = r_duty;
  assign pulse_dessert = r_des;
  assign pulse_num     = r_pnum;
  assign PAT           = r_pat;
  assign cur_idx       = r_cur_idx;
  assign seq_busy      = (r_state != StIdle);
  assign seq_done      = (r_state == StDone);

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl: stimulus pushes expected bursts and
// completions, a monitor pops them as pwm_en rises or seq_done pulses.
module tb_pattern_seq_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 2;
  localparam int unsigned TO_CYC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [39:0]   cfg_wdata;
  logic [AW:0]   seq_len;
  logic [7:0]    loop_num;
  logic          start, stop, gen_busy, gen_valid;
  logic          pwm_en, seq_busy, seq_done, seq_err;
  logic [7:0]    duty_num, pulse_num, PAT;
  logic [15:0]   pulse_dessert;
  logic [AW-1:0] cur_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit gen_hold = 1'b0;

  typedef struct {
    bit            is_done;
    logic [39:0]   ent;
    logic [AW-1:0] idx;
    bit            err;
  } ev_t;

  ev_t         exp_q[$];
  logic [39:0] mdl_tbl [DEPTH];

  pattern_seq_ctrl #(
    .DEPTH      (DEPTH),
    ._PAT_WIDTH (8),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .seq_len      (seq_len),
    .loop_num     (loop_num),
    .start        (start),
    .stop         (stop),
    .gen_busy     (gen_busy),
    .gen_valid    (gen_valid),
    .pwm_en       (pwm_en),
    .duty_num     (duty_num),
    .pulse_dessert(pulse_dessert),
    .pulse_num    (pulse_num),
    .PAT          (PAT),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .cur_idx      (cur_idx),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int duty, input int des, input int pnum, input int pat);
    return {8'(pat), 8'(pnum), 16'(des), 8'(duty)};
  endfunction

  task automatic push_pulse(input int i);
    ev_t e;
    e.is_done = 1'b0;
    e.ent     = mdl_tbl[i];
    e.idx     = AW'(i);
    e.err     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit err);
    ev_t e;
    e.is_done = 1'b1;
    e.ent     = '0;
    e.idx     = '0;
    e.err     = err;
    exp_q.push_back(e);
  endtask

  // Reference behaviour: every pass plays entries 0..min(len,DEPTH)-1, then one completion
  task automatic model_run(input int len, input int loops);
    int eff;
    eff = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    for (int p = 0; p < loops; p++) begin
      for (int i = 0; i < eff; i++) push_pulse(i);
    end
    push_done(1'b0);
  endtask

  task automatic write_entry(input int addr, input logic [39:0] data, input bit to_model);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (to_model) mdl_tbl[addr] = data;
  endtask

  // Issue start, return clocks from the sampling edge to the first pwm_en high
  task automatic start_seq(output int lat);
    @(negedge clk);
    start = 1'b1;
    lat   = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (pwm_en) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_no_pwm: pwm_en stayed 0 for 30 clocks, expected a burst");
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (seq_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, seq_busy, 1'b0);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic try_bad_start(input string name, input bit w_stop, input bit w_busy,
                               input logic [AW:0] len);
    @(negedge clk);
    seq_len  = len;
    start    = 1'b1;
    stop     = w_stop;
    gen_busy = w_busy;
    @(negedge clk);
    start    = 1'b0;
    stop     = 1'b0;
    gen_busy = 1'b0;
    @(negedge clk);
    chk(name, seq_busy, 1'b0);
  endtask

  task automatic pulse_gen_valid();
    @(negedge clk);
    gen_valid = 1'b1;
    @(negedge clk);
    gen_valid = 1'b0;
  endtask

  // Monitor: compare each burst start and each completion with the scoreboard
  initial begin : monitor
    logic prev_pwm;
    ev_t  e;
    prev_pwm = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_pwm && (pulse_num != 8'd0)) chk("finite_pulse_width", pwm_en, 1'b0);
      if (pwm_en && !prev_pwm) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got burst idx=%0d expected nothing", cur_idx);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_order: got burst expected seq_done");
          end else begin
            chk("pulse_idx", cur_idx, e.idx);
            chk("pulse_fields", {PAT, pulse_num, pulse_dessert, duty_num}, e.ent);
          end
        end
      end
      if (seq_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got seq_done expected nothing");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_order: got seq_done expected burst idx=%0d", e.idx);
          end else begin
            chk("done_err", seq_err, e.err);
          end
        end
      end
      prev_pwm = pwm_en;
    end
  end

  // Downstream generator: end-of-burst pulse 1..4 clocks after each burst starts
  initial begin : responder
    int   pend;
    logic prev;
    pend = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_hold) begin
        pend = 0;
      end else begin
        gen_valid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) gen_valid = 1'b1;
        end
        if (pwm_en && !prev) pend = int'($urandom_range(1, 4));
      end
      prev = pwm_en;
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, highs, n;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    seq_len = 3'd1; loop_num = 8'd1;
    start = 1'b0; stop = 1'b0; gen_busy = 1'b0; gen_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mdl_tbl[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {pwm_en, seq_busy, seq_done, seq_err}, 4'b0);
    chk("rst_fields", {cur_idx, PAT, pulse_num, pulse_dessert, duty_num}, '0);

    // Two-entry single pass with start latency
    write_entry(0, mk(2, 4, 1, 8'h05), 1'b1);
    write_entry(1, mk(1, 2, 2, 8'h03), 1'b1);
    seq_len = 3'd2; loop_num = 8'd1;
    model_run(2, 1);
    start_seq(lat);
    chk("start_to_pwm_latency", lat, 2);
    wait_idle("basic", 200);

    // Three passes of two entries
    loop_num = 8'd3;
    model_run(2, 3);
    start_seq(lat);
    wait_idle("loop3", 300);

    // Randomized tables, lengths (including > DEPTH) and pass counts
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < int'(DEPTH); a++)
        write_entry(a, mk($urandom_range(0, 255), $urandom_range(0, 65535),
                          $urandom_range(1, 255), $urandom_range(0, 255)), 1'b1);
      seq_len  = 3'($urandom_range(1, 7));
      loop_num = 8'($urandom_range(1, 3));
      model_run(int'(seq_len), int'(loop_num));
      start_seq(lat);
      chk("rand_latency", lat, 2);
      wait_idle("rand", 400);
    end

    // Starts that must be ignored
    try_bad_start("start_with_stop_ignored", 1'b1, 1'b0, 3'd2);
    try_bad_start("start_gen_busy_ignored", 1'b0, 1'b1, 3'd2);
    try_bad_start("start_len0_ignored", 1'b0, 1'b0, 3'd0);

    // Stop while loading: completion, no burst
    seq_len = 3'd2; loop_num = 8'd1;
    push_done(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle("stop_in_load", 20);

    // Infinite entry held until stop
    gen_hold = 1'b1;
    write_entry(0, mk(3, 7, 0, 8'hA5), 1'b1);
    seq_len = 3'd1; loop_num = 8'd1;
    push_pulse(0); push_done(1'b0);
    start_seq(lat);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm_en) highs++;
    end
    chk("inf_pwm_held", highs, 50);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("inf_pwm_low_after_stop", pwm_en, 1'b0);
    chk("inf_busy_until_gen_valid", seq_busy, 1'b1);
    pulse_gen_valid();
    wait_idle("infinite", 20);

    // Stop during WAIT of entry 0: entry 1 never loaded
    write_entry(0, mk(9, 9, 4, 8'h11), 1'b1);
    write_entry(1, mk(8, 8, 5, 8'h22), 1'b1);
    seq_len = 3'd2;
    push_pulse(0); push_done(1'b0);
    start_seq(lat);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) @(negedge clk);
    pulse_gen_valid();
    wait_idle("stop_in_wait", 20);
    chk("stop_no_advance_idx", cur_idx, 0);

    // Table write while busy is dropped
    seq_len = 3'd1;
    push_pulse(0); push_done(1'b0);
    start_seq(lat);
    write_entry(1, mk(255, 65535, 255, 8'hFF), 1'b0);
    pulse_gen_valid();
    wait_idle("busy_write", 20);
    gen_hold = 1'b0;
    seq_len = 3'd2;
    model_run(2, 1);
    start_seq(lat);
    wait_idle("after_busy_write", 200);

    // Write and start in the same cycle: new data used
    mdl_tbl[0] = mk(6, 300, 3, 8'h5A);
    seq_len = 3'd1;
    model_run(1, 1);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = mdl_tbl[0]; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle("write_and_start", 100);

    // Reset in WAIT: outputs cleared, no completion, table cleared
    gen_hold = 1'b1;
    push_pulse(0);
    start_seq(lat);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", {pwm_en, seq_busy, seq_done, seq_err}, 4'b0);
    chk("midrst_fields", {cur_idx, PAT, pulse_num, pulse_dessert, duty_num}, '0);
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mdl_tbl[i] = '0;
    repeat (5) @(negedge clk);
    chk("midrst_drain", exp_q.size(), 0);
    seq_len = 3'd2;
    push_pulse(0); push_done(1'b0);
    start_seq(lat);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    pulse_gen_valid();
    wait_idle("cleared_table", 20);

`ifdef PATTERN_SEQ_TIMEOUT_EN
    // Watchdog: withheld gen_valid on a finite entry
    write_entry(0, mk(1, 1, 1, 8'h77), 1'b1);
    seq_len = 3'd1;
    push_pulse(0); push_done(1'b1);
    start_seq(lat);
    n = 0;
    while (!seq_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, TO_CYC);
    wait_idle("timeout", 10);
    chk("timeout_err_sticky", seq_err, 1'b1);
    gen_hold = 1'b0;
    model_run(1, 1);
    start_seq(lat);
    chk("timeout_err_cleared", seq_err, 1'b0);
    wait_idle("after_timeout", 100);
`else
    n = 0;
`endif
    gen_hold = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
